dnn_mac_driver: RTL and testbench

Initiator-side sequencer for the dot-product DNN accelerator. It sits between an upstream operand stream and the accelerator's MAC and memory-read interfaces. On `start` it issues exactly NUM_OPS 4-element MAC operations, honouring `RDY_mac` backpressure. It then triggers and collects the accelerator's result read-out and re-emits each result with its index, reporting a signed argmax over the whole batch.

---
 rtl/dnn_mac_driver.sv | 148 ++++++++++++++
 tb/tb_dnn_mac_driver.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_mac_driver.sv
// Initiator-side sequencer for the dot-product DNN accelerator: issues one batch of
// MAC operations, triggers the result read-out, re-emits each result with its index, tracks argmax.
module dnn_mac_driver #(
    parameter int NUM_OPS = 64,
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_vecA,
    input  logic [63:0] in_vecB,
    output logic        EN_mac,
    output logic [15:0] mac_vecA_0,
    output logic [15:0] mac_vecA_1,
    output logic [15:0] mac_vecA_2,
    output logic [15:0] mac_vecA_3,
    output logic [15:0] mac_vecB_0,
    output logic [15:0] mac_vecB_1,
    output logic [15:0] mac_vecB_2,
    output logic [15:0] mac_vecB_3,
    input  logic        RDY_mac,
    output logic        EN_readMem,
    input  logic        VALID_memVal,
    input  logic [31:0] memVal_data,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [5:0]  res_idx,
    output logic        done,
    output logic [31:0] max_val,
    output logic [5:0]  max_idx,
    output logic        err,
    output logic [2:0]  dbgState
);

    // Upstream and MAC handshakes: a transfer happens in a cycle where valid and ready
    // are both high; in_ready is only asserted in a cycle where the op is also issued.
    localparam int CNT_W = $clog2(NUM_OPS + 1);
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [5:0] LAST_BEAT = 6'(NUM_OPS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_DRAIN_REQ = 3'd2,
        S_DRAIN     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t state, stateNext;

    logic [CNT_W-1:0] issueCnt;
    logic [5:0]       beatCnt;
    logic [TO_W-1:0]  toCnt;
    logic             errQ, setErr;
    logic             resValidQ;
    logic [31:0]      resDataQ, maxValQ;
    logic [5:0]       resIdxQ, maxIdxQ;
    logic             inIssue, fire, capture, lastBeat, toExpired;

    assign inIssue   = (state == S_ISSUE);
    assign fire      = inIssue && (issueCnt < CNT_W'(NUM_OPS)) && in_valid && RDY_mac;
    assign capture   = VALID_memVal && ((state == S_DRAIN_REQ) || (state == S_DRAIN));
    assign lastBeat  = (beatCnt == LAST_BEAT);
    assign toExpired = (toCnt == TO_W'(TIMEOUT - 1));

    always_comb begin
        stateNext = state;
        setErr    = 1'b0;
        case (state)
            S_IDLE:      if (start) stateNext = S_ISSUE;
            S_ISSUE:     if (fire && (issueCnt == CNT_W'(NUM_OPS - 1))) stateNext = S_DRAIN_REQ;
            S_DRAIN_REQ: begin
                // A beat arriving on the expiry cycle wins over the timeout.
                if (VALID_memVal) begin
                    stateNext = lastBeat ? S_DONE : S_DRAIN;
                end else if (toExpired) begin
                    setErr    = 1'b1;
                    stateNext = S_DONE;
                end
            end
            S_DRAIN:     if (VALID_memVal && lastBeat) stateNext = S_DONE;
            S_DONE:      stateNext = S_IDLE;
            default:     stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            issueCnt  <= '0;
            beatCnt   <= '0;
            toCnt     <= '0;
            errQ      <= 1'b0;
            resValidQ <= 1'b0;
            resDataQ  <= '0;
            resIdxQ   <= '0;
            maxValQ   <= '0;
            maxIdxQ   <= '0;
        end else begin
            state     <= stateNext;
            resValidQ <= capture;
            if ((state == S_IDLE) && start) begin
                errQ     <= 1'b0;
                issueCnt <= '0;
                beatCnt  <= '0;
                toCnt    <= '0;
            end
            if (fire) issueCnt <= issueCnt + CNT_W'(1);
            if (state == S_DRAIN_REQ) toCnt <= toCnt + TO_W'(1);
            if (setErr) errQ <= 1'b1;
            if (capture) begin
                resDataQ <= memVal_data;
                resIdxQ  <= beatCnt;
                beatCnt  <= beatCnt + 6'd1;
                // Strictly-greater replacement keeps the lowest index on ties.
                if ((beatCnt == 6'd0) || ($signed(memVal_data) > $signed(maxValQ))) begin
                    maxValQ <= memVal_data;
                    maxIdxQ <= beatCnt;
                end
            end
        end
    end

    assign busy       = (state != S_IDLE);
    assign in_ready   = fire;
    assign EN_mac     = fire;
    assign EN_readMem = (state == S_DRAIN_REQ);
    assign done       = (state == S_DONE);
    assign mac_vecA_0 = inIssue ? in_vecA[15:0]  : 16'd0;
    assign mac_vecA_1 = inIssue ? in_vecA[31:16] : 16'd0;
    assign mac_vecA_2 = inIssue ? in_vecA[47:32] : 16'd0;
    assign mac_vecA_3 = inIssue ? in_vecA[63:48] : 16'd0;
    assign mac_vecB_0 = inIssue ? in_vecB[15:0]  : 16'd0;
    assign mac_vecB_1 = inIssue ? in_vecB[31:16] : 16'd0;
    assign mac_vecB_2 = inIssue ? in_vecB[47:32] : 16'd0;
    assign mac_vecB_3 = inIssue ? in_vecB[63:48] : 16'd0;
    assign res_valid  = resValidQ;
    assign res_data   = resDataQ;
    assign res_idx    = resIdxQ;
    assign max_val    = maxValQ;
    assign max_idx    = maxIdxQ;
    assign err        = errQ;
    assign dbgState   = state;

endmodule

// File: tb/tb_dnn_mac_driver.sv
// Bench for dnn_mac_driver: operand driver, accelerator stub and per-scenario checks
// against dot products and argmax computed from the chosen operand values.
module tb_dnn_mac_driver;
    localparam int NUM_OPS = 64;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, RDY_mac, VALID_memVal;
    logic [63:0] in_vecA, in_vecB;
    logic [31:0] memVal_data;
    logic        busy, in_ready, EN_mac, EN_readMem, res_valid, done, err;
    logic [15:0] mac_vecA_0, mac_vecA_1, mac_vecA_2, mac_vecA_3;
    logic [15:0] mac_vecB_0, mac_vecB_1, mac_vecB_2, mac_vecB_3;
    logic [31:0] res_data, max_val;
    logic [5:0]  res_idx, max_idx;
    logic [2:0]  dbg_state;

    dnn_mac_driver #(.NUM_OPS(NUM_OPS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_vecA(in_vecA), .in_vecB(in_vecB),
        .EN_mac(EN_mac),
        .mac_vecA_0(mac_vecA_0), .mac_vecA_1(mac_vecA_1), .mac_vecA_2(mac_vecA_2), .mac_vecA_3(mac_vecA_3),
        .mac_vecB_0(mac_vecB_0), .mac_vecB_1(mac_vecB_1), .mac_vecB_2(mac_vecB_2), .mac_vecB_3(mac_vecB_3),
        .RDY_mac(RDY_mac), .EN_readMem(EN_readMem), .VALID_memVal(VALID_memVal),
        .memVal_data(memVal_data), .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .done(done), .max_val(max_val), .max_idx(max_idx), .err(err), .dbgState(dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;

    // operand stream and reference results
    logic [63:0] op_a[$];
    logic [63:0] op_b[$];
    logic [31:0] exp_q[$];
    logic rst_r = 1'b1;
    logic start_r = 1'b0;
    int drv_idx = 0;
    int valid_mode = 0;
    int rdy_low_from = 0;
    int rdy_low_len = 0;

    // accelerator stub
    logic [31:0] acc_buf[$];
    int rd_ptr = 0;
    bit streaming = 0;
    int stream_at = 0;
    bit stub_silent = 0;
    bit stray_en = 0;
    int stub_lat_fixed = 0;

    // observations
    logic [31:0] got_data[$];
    logic [5:0]  got_idx[$];
    int fire_cnt, first_fire, last_fire, rdm_cnt, rdm_first, done_cnt, done_cyc, viol;
    logic [31:0] done_max_val;
    logic [5:0]  done_max_idx, done_last_idx;
    logic done_err, done_rv, done_rdm, busy_after_done, busy_first, err_after_start;

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic logic [31:0] acc_dot(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
        int s;
        s = $signed(a0) * $signed(b0) + $signed(a1) * $signed(b1)
          + $signed(a2) * $signed(b2) + $signed(a3) * $signed(b3);
        return 32'(s);
    endfunction

    task automatic clear_ops();
        op_a.delete(); op_b.delete(); exp_q.delete();
    endtask

    task automatic add_op(input int a0, a1, a2, a3, b0, b1, b2, b3);
        int a[4];
        int b[4];
        int s;
        logic [63:0] pa, pb;
        a = '{a0, a1, a2, a3};
        b = '{b0, b1, b2, b3};
        s = 0;
        for (int i = 0; i < 4; i++) begin
            pa[16*i +: 16] = 16'(a[i]);
            pb[16*i +: 16] = 16'(b[i]);
            s += a[i] * b[i];
        end
        op_a.push_back(pa); op_b.push_back(pb); exp_q.push_back(32'(s));
    endtask

    function automatic int exp_argmax();
        int best = 0;
        for (int k = 1; k < exp_q.size(); k++)
            if ($signed(exp_q[k]) > $signed(exp_q[best])) best = k;
        return best;
    endfunction

    // one clock cycle: drive at negedge, sample 1 ns later
    task automatic tick();
        bit vpat;
        @(negedge clk);
        cyc++;
        rst = rst_r;
        start = start_r;
        vpat = (valid_mode == 0) || (cyc % 2 == 0);
        in_valid = (drv_idx < op_a.size()) && vpat;
        in_vecA = in_valid ? op_a[drv_idx] : {$urandom, $urandom};
        in_vecB = in_valid ? op_b[drv_idx] : {$urandom, $urandom};
        RDY_mac = !(rdy_low_len > 0 && cyc >= rdy_low_from && cyc < rdy_low_from + rdy_low_len);
        VALID_memVal = 1'b0;
        memVal_data = $urandom;
        if (streaming && cyc >= stream_at && rd_ptr < acc_buf.size()) begin
            if (cyc == stream_at || $urandom_range(0, 3) != 0) begin
                VALID_memVal = 1'b1;
                memVal_data = acc_buf[rd_ptr];
                rd_ptr++;
            end
        end else if (stray_en && !streaming && acc_buf.size() < NUM_OPS) begin
            VALID_memVal = 1'($urandom_range(0, 1));
        end
        #1;
        if (EN_mac !== in_ready) viol++;
        if (EN_mac === 1'b1 && (!RDY_mac || !in_valid)) viol++;
        if (EN_mac === 1'b1) begin
            fire_cnt++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
            acc_buf.push_back(acc_dot(mac_vecA_0, mac_vecA_1, mac_vecA_2, mac_vecA_3,
                                      mac_vecB_0, mac_vecB_1, mac_vecB_2, mac_vecB_3));
        end
        if (in_ready === 1'b1) drv_idx++;
        if (EN_readMem === 1'b1) begin
            rdm_cnt++;
            if (rdm_first < 0) rdm_first = cyc;
            if (!streaming && !stub_silent && acc_buf.size() == NUM_OPS) begin
                streaming = 1;
                stream_at = cyc + ((stub_lat_fixed > 0) ? stub_lat_fixed : int'($urandom_range(1, 5)));
            end
        end
        if (res_valid === 1'b1) begin
            got_data.push_back(res_data);
            got_idx.push_back(res_idx);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_max_val = max_val; done_max_idx = max_idx; done_err = err;
            done_rv = res_valid; done_rdm = EN_readMem; done_last_idx = res_idx;
        end
        if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after_done = busy;
    endtask

    task automatic run_batch(input int start_at_fire, input int start_at_res);
        drv_idx = 0; fire_cnt = 0; first_fire = -1; last_fire = -1; rdm_cnt = 0; rdm_first = -1;
        acc_buf.delete(); rd_ptr = 0; streaming = 0; got_data.delete(); got_idx.delete();
        done_cnt = 0; done_cyc = -1; viol = 0; busy_after_done = 1'bx;
        start_r = 1'b1; tick(); start_r = 1'b0;
        tick(); busy_first = busy; err_after_start = err;
        for (int i = 0; i < 1500 && done_cnt == 0; i++) begin
            start_r = (start_at_fire > 0 && fire_cnt == start_at_fire) ||
                      (start_at_res > 0 && got_data.size() == start_at_res);
            tick();
        end
        start_r = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset();
        clear_ops();
        add_op(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        stray_en = 1; rst_r = 1'b1;
        repeat (3) tick();
        n_cmp++; if ({busy, in_ready, EN_mac, EN_readMem, res_valid, done, err} !== 7'd0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0", {busy, in_ready, EN_mac, EN_readMem, res_valid, done, err}); end
        n_cmp++; if ({mac_vecA_0, mac_vecA_1, mac_vecA_2, mac_vecA_3, mac_vecB_0, mac_vecB_1, mac_vecB_2, mac_vecB_3} !== 128'd0) begin
            n_fail++; $display("FAIL reset_mac_vec: got nonzero operands, expected 0"); end
        n_cmp++; if ({res_data, res_idx, max_val, max_idx} !== 76'd0) begin
            n_fail++; $display("FAIL reset_data: got res %h/%0d max %h/%0d expected 0", res_data, res_idx, max_val, max_idx); end
        rst_r = 1'b0; stray_en = 0;
        tick();
    endtask

    task automatic test_basic();
        clear_ops();
        for (int k = 0; k < NUM_OPS; k++) add_op(k, 1, 0, 0, 1, 1, 0, 0);
        run_batch(0, 0);
        n_cmp++; if (busy_first !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy_first); end
        n_cmp++; if (fire_cnt != NUM_OPS) begin n_fail++; $display("FAIL basic_fires: got %0d expected %0d", fire_cnt, NUM_OPS); end
        n_cmp++; if (last_fire - first_fire != NUM_OPS - 1) begin
            n_fail++; $display("FAIL basic_consecutive: got span %0d expected %0d", last_fire - first_fire, NUM_OPS - 1); end
        n_cmp++; if (rdm_first != last_fire + 1) begin
            n_fail++; $display("FAIL basic_drain_req_entry: got cycle %0d expected %0d", rdm_first, last_fire + 1); end
        n_cmp++; if (got_data.size() != exp_q.size()) begin
            n_fail++; $display("FAIL basic_res_count: got %0d expected %0d", got_data.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_data.size(); k++) begin
            n_cmp++; if (got_data[k] !== exp_q[k] || got_idx[k] !== 6'(k)) begin
                n_fail++; $display("FAIL basic_res[%0d]: got %h@%0d expected %h@%0d", k, got_data[k], got_idx[k], exp_q[k], k); end
        end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (done_max_val !== exp_q[exp_argmax()] || done_max_idx !== 6'(exp_argmax())) begin
            n_fail++; $display("FAIL basic_max: got %h@%0d expected %h@%0d", done_max_val, done_max_idx, exp_q[exp_argmax()], exp_argmax()); end
        n_cmp++; if (done_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", done_err); end
        n_cmp++; if (done_rv !== 1'b1 || done_last_idx !== 6'(NUM_OPS - 1)) begin
            n_fail++; $display("FAIL basic_last_with_done: got rv %b idx %0d expected 1 idx %0d", done_rv, done_last_idx, NUM_OPS - 1); end
        n_cmp++; if (busy_after_done !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after_done: got busy %b expected 0", busy_after_done); end
    endtask

    task automatic test_backpressure();
        clear_ops();
        for (int k = 0; k < NUM_OPS; k++)
            add_op(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        valid_mode = 1; stray_en = 1;
        rdy_low_from = cyc + 30; rdy_low_len = 5;
        run_batch(0, 0);
        valid_mode = 0; stray_en = 0; rdy_low_len = 0;
        n_cmp++; if (fire_cnt != NUM_OPS) begin n_fail++; $display("FAIL bp_fires: got %0d expected %0d", fire_cnt, NUM_OPS); end
        n_cmp++; if (viol != 0) begin n_fail++; $display("FAIL bp_handshake: got %0d violations expected 0", viol); end
        n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (got_data.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_res_count: got %0d expected %0d", got_data.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_data.size(); k++) begin
            n_cmp++; if (got_data[k] !== exp_q[k] || got_idx[k] !== 6'(k)) begin
                n_fail++; $display("FAIL bp_res[%0d]: got %h@%0d expected %h@%0d", k, got_data[k], got_idx[k], exp_q[k], k); end
        end
        n_cmp++; if (done_max_val !== exp_q[exp_argmax()] || done_max_idx !== 6'(exp_argmax())) begin
            n_fail++; $display("FAIL bp_max: got %h@%0d expected %h@%0d", done_max_val, done_max_idx, exp_q[exp_argmax()], exp_argmax()); end
    endtask

    task automatic test_argmax();
        for (int pass = 0; pass < 2; pass++) begin
            clear_ops();
            for (int k = 0; k < NUM_OPS; k++) begin
                int v;
                if (pass == 0) v = (k == 10 || k == 20) ? 100 : -5;
                else v = (k == 40) ? -1 : -int'($urandom_range(2, 30000));
                add_op(v, rnd16(), rnd16(), rnd16(), 1, 0, 0, 0);
            end
            run_batch(0, 0);
            n_cmp++; if (done_max_val !== exp_q[exp_argmax()] || done_max_idx !== 6'(exp_argmax())) begin
                n_fail++; $display("FAIL argmax_pass%0d: got %h@%0d expected %h@%0d", pass, done_max_val, done_max_idx, exp_q[exp_argmax()], exp_argmax()); end
            n_cmp++; if (got_data.size() != NUM_OPS || got_data[NUM_OPS-1] !== exp_q[NUM_OPS-1]) begin
                n_fail++; $display("FAIL argmax_results_pass%0d: got %0d results expected %0d", pass, got_data.size(), NUM_OPS); end
        end
    endtask

    task automatic test_timeout();
        clear_ops();
        for (int k = 0; k < NUM_OPS; k++) add_op(rnd16(), 0, 0, 0, 1, 0, 0, 0);
        stub_silent = 1;
        run_batch(0, 0);
        n_cmp++; if (rdm_cnt != TIMEOUT) begin n_fail++; $display("FAIL to_readmem_cycles: got %0d expected %0d", rdm_cnt, TIMEOUT); end
        n_cmp++; if (done_cnt != 1 || done_cyc - rdm_first != TIMEOUT) begin
            n_fail++; $display("FAIL to_done_timing: got done %0d at +%0d expected 1 at +%0d", done_cnt, done_cyc - rdm_first, TIMEOUT); end
        n_cmp++; if (done_err !== 1'b1 || done_rdm !== 1'b0) begin
            n_fail++; $display("FAIL to_err_at_done: got err %b readmem %b expected 1 0", done_err, done_rdm); end
        repeat (3) tick();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b expected 1", err); end
        stub_silent = 0;
        clear_ops();
        for (int k = 0; k < NUM_OPS; k++) add_op(rnd16(), rnd16(), 0, 0, rnd16(), rnd16(), 0, 0);
        run_batch(0, 0);
        n_cmp++; if (err_after_start !== 1'b0 || done_err !== 1'b0) begin
            n_fail++; $display("FAIL to_err_clear: got %b/%b expected 0/0", err_after_start, done_err); end
        n_cmp++; if (got_data.size() != NUM_OPS || got_data[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL to_recover_results: got %0d results expected %0d", got_data.size(), NUM_OPS); end
    endtask

    task automatic test_timeout_edge();
        clear_ops();
        for (int k = 0; k < NUM_OPS; k++) add_op(rnd16(), rnd16(), rnd16(), 0, rnd16(), rnd16(), rnd16(), 0);
        stub_lat_fixed = TIMEOUT - 1;
        run_batch(0, 0);
        stub_lat_fixed = 0;
        n_cmp++; if (done_cnt != 1 || done_err !== 1'b0) begin
            n_fail++; $display("FAIL edge_beat_wins: got done %0d err %b expected 1 0", done_cnt, done_err); end
        n_cmp++; if (rdm_cnt != TIMEOUT) begin n_fail++; $display("FAIL edge_readmem_cycles: got %0d expected %0d", rdm_cnt, TIMEOUT); end
        n_cmp++; if (got_data.size() != exp_q.size()) begin
            n_fail++; $display("FAIL edge_res_count: got %0d expected %0d", got_data.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_data.size(); k++) begin
            n_cmp++; if (got_data[k] !== exp_q[k] || got_idx[k] !== 6'(k)) begin
                n_fail++; $display("FAIL edge_res[%0d]: got %h@%0d expected %h@%0d", k, got_data[k], got_idx[k], exp_q[k], k); end
        end
    endtask

    task automatic test_reset_mid_issue();
        clear_ops();
        for (int k = 0; k < NUM_OPS; k++) add_op(rnd16(), rnd16(), rnd16(), rnd16(), 1, 1, 1, 1);
        drv_idx = 0; fire_cnt = 0; acc_buf.delete(); streaming = 0;
        start_r = 1'b1; tick(); start_r = 1'b0;
        for (int i = 0; i < 200 && fire_cnt < 30; i++) tick();
        rst_r = 1'b1; tick();
        rst_r = 1'b0; tick();
        n_cmp++; if ({busy, in_ready, EN_mac, EN_readMem, res_valid, done, err} !== 7'd0) begin
            n_fail++; $display("FAIL midrst_flags: got %b expected 0", {busy, in_ready, EN_mac, EN_readMem, res_valid, done, err}); end
        n_cmp++; if ({mac_vecA_0, mac_vecA_3, mac_vecB_0, mac_vecB_3, res_data, res_idx, max_val, max_idx} !== 140'd0) begin
            n_fail++; $display("FAIL midrst_data: got nonzero data outputs, expected 0"); end
        clear_ops();
        for (int k = 0; k < NUM_OPS; k++) add_op(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        run_batch(0, 0);
        n_cmp++; if (fire_cnt != NUM_OPS || done_cnt != 1) begin
            n_fail++; $display("FAIL midrst_rerun: got %0d fires %0d done expected %0d 1", fire_cnt, done_cnt, NUM_OPS); end
        for (int k = 0; k < exp_q.size() && k < got_data.size(); k++) begin
            n_cmp++; if (got_data[k] !== exp_q[k] || got_idx[k] !== 6'(k)) begin
                n_fail++; $display("FAIL midrst_res[%0d]: got %h@%0d expected %h@%0d", k, got_data[k], got_idx[k], exp_q[k], k); end
        end
    endtask

    task automatic test_start_while_busy();
        clear_ops();
        for (int k = 0; k < NUM_OPS; k++) add_op(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        run_batch(10, 5);
        n_cmp++; if (fire_cnt != NUM_OPS || done_cnt != 1) begin
            n_fail++; $display("FAIL swb_counts: got %0d fires %0d done expected %0d 1", fire_cnt, done_cnt, NUM_OPS); end
        n_cmp++; if (got_data.size() != exp_q.size()) begin
            n_fail++; $display("FAIL swb_res_count: got %0d expected %0d", got_data.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_data.size(); k++) begin
            n_cmp++; if (got_data[k] !== exp_q[k] || got_idx[k] !== 6'(k)) begin
                n_fail++; $display("FAIL swb_res[%0d]: got %h@%0d expected %h@%0d", k, got_data[k], got_idx[k], exp_q[k], k); end
        end
        n_cmp++; if (busy_after_done !== 1'b0) begin n_fail++; $display("FAIL swb_idle: got busy %b expected 0", busy_after_done); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; RDY_mac = 1'b1; VALID_memVal = 1'b0;
        in_vecA = '0; in_vecB = '0; memVal_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_argmax();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_issue();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
